seq_accumulator_ctrl: RTL and testbench

Parametrised, controlled successor to the fixed 8-bit sequence adder. It accumulates a programmed number N of valid input samples into a WIDTH-bit register. Per-run add/subtract mode is selectable, and overflow handling is wrap or saturate, fixed at elaboration. A START/BUSY/DONE handshake lets a controller launch runs and collect the result. It sits between a sample source and a consumer that reads Q after DONE.

---
 rtl/seq_accumulator_ctrl_pkg.sv | 18 +
 rtl/seq_accumulator_ctrl_add_sub_sat.sv | 39 +++
 rtl/seq_accumulator_ctrl.sv | 134 +++++++++++++
 tb/tb_seq_accumulator_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_accumulator_ctrl_pkg.sv
// Shared definitions for the controlled sequence accumulator.
// Provides the FSM state encoding and the add/subtract mode constants
// used by the top-level controller and the arithmetic sub-module.
package seq_accumulator_ctrl_pkg;

  // Two-bit state encoding; the fourth code (2'b11) is unused and the
  // controller steers it back to idle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Per-run arithmetic direction, latched when a run is accepted.
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/seq_accumulator_ctrl_add_sub_sat.sv
// add_sub_sat: combinational add/subtract with wrap or saturate handling.
// Ports:
//   Q    - current accumulator value (unsigned, WIDTH bits)
//   A    - sample operand (unsigned, WIDTH bits)
//   MODE - MODE_ADD computes Q+A, MODE_SUB computes Q-A
//   RES  - result after wrap/saturation (WIDTH bits)
//   OV   - carry-out on add, borrow on subtract
module add_sub_sat
  import seq_accumulator_ctrl_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] A,
  input  logic             MODE,
  output logic [WIDTH-1:0] RES,
  output logic             OV
);

  logic [WIDTH:0] ext;

  // The extra top bit of the widened result is the carry on add and the
  // borrow on subtract, so one bit serves as the overflow indication for
  // both directions. Saturation clamps toward the side that overflowed.
  always_comb begin
    if (MODE == MODE_SUB) begin
      ext = {1'b0, Q} - {1'b0, A};
    end else begin
      ext = {1'b0, Q} + {1'b0, A};
    end
    OV  = ext[WIDTH];
    RES = ext[WIDTH-1:0];
    if ((SATURATE != 0) && OV) begin
      RES = (MODE == MODE_SUB) ? '0 : '1;
    end
  end

endmodule

// File: rtl/seq_accumulator_ctrl.sv
// seq_accumulator_ctrl: accumulates a programmed number of valid samples
// under a START/BUSY/DONE handshake.
// Ports:
//   CLK     - clock, rising edge active
//   RST     - asynchronous active-high reset
//   START   - launch a run (only honoured in idle)
//   N       - run length, latched on an accepted START
//   MODE    - 0 add, 1 subtract, latched on an accepted START
//   A       - sample operand
//   A_VALID - A is consumed on this edge while accumulating
//   Q       - registered accumulator value
//   CNT     - samples consumed in the current or last run
//   BUSY    - high while accumulating
//   DONE    - one-cycle completion pulse
//   OVF     - sticky overflow/underflow flag for the current or last run
module seq_accumulator_ctrl
  import seq_accumulator_ctrl_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int COUNT_W  = 4,
  parameter int SATURATE = 0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [COUNT_W-1:0] N,
  input  logic               MODE,
  input  logic [WIDTH-1:0]   A,
  input  logic               A_VALID,
  output logic [WIDTH-1:0]   Q,
  output logic [COUNT_W-1:0] CNT,
  output logic               BUSY,
  output logic               DONE,
  output logic               OVF
);

  state_t             state;
  state_t             next_state;
  logic [WIDTH-1:0]   acc;
  logic [COUNT_W-1:0] cnt;
  logic [COUNT_W-1:0] cnt_inc;
  logic [COUNT_W-1:0] n_lat;
  logic               mode_lat;
  logic               ovf;
  logic               start_run;
  logic               consume;
  logic [WIDTH-1:0]   sum_res;
  logic               sum_ov;

  assign cnt_inc = cnt + COUNT_W'(1);

  add_sub_sat #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_add_sub_sat (
    .Q    (acc),
    .A    (A),
    .MODE (mode_lat),
    .RES  (sum_res),
    .OV   (sum_ov)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake decode. A zero-length run skips ACCUM so BUSY
  // never rises for it; the last sample is detected with the incremented
  // count so DONE follows the consuming edge directly.
  always_comb begin
    next_state = state;
    start_run  = 1'b0;
    consume    = 1'b0;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          start_run  = 1'b1;
          next_state = (N == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        BUSY = 1'b1;
        if (A_VALID) begin
          consume = 1'b1;
          if (cnt_inc == n_lat) begin
            next_state = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        DONE       = 1'b1;
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath registers. An accepted START clears the previous result and
  // captures the run parameters; afterwards only consumed samples change
  // the accumulator, count and sticky overflow flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      n_lat    <= '0;
      mode_lat <= MODE_ADD;
    end else if (start_run) begin
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      n_lat    <= N;
      mode_lat <= MODE;
    end else if (consume) begin
      acc <= sum_res;
      cnt <= cnt_inc;
      ovf <= ovf | sum_ov;
    end
  end

  assign Q   = acc;
  assign CNT = cnt;
  assign OVF = ovf;

endmodule

// File: tb/tb_seq_accumulator_ctrl.sv
// Directed testbench for seq_accumulator_ctrl. Two instances share the
// same stimulus: one wraps, one saturates.
module tb_seq_accumulator_ctrl;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic       start;
  logic [3:0] n;
  logic       mode;
  logic [7:0] a;
  logic       a_valid;

  logic [7:0] q_w, q_s;
  logic [3:0] cnt_w, cnt_s;
  logic       busy_w, busy_s, done_w, done_s, ovf_w, ovf_s;

  int check_count = 0;
  int error_count = 0;

  seq_accumulator_ctrl #(.WIDTH(8), .COUNT_W(4), .SATURATE(0)) dut_wrap (
    .CLK(clk), .RST(rst), .START(start), .N(n), .MODE(mode), .A(a),
    .A_VALID(a_valid), .Q(q_w), .CNT(cnt_w), .BUSY(busy_w), .DONE(done_w),
    .OVF(ovf_w)
  );

  seq_accumulator_ctrl #(.WIDTH(8), .COUNT_W(4), .SATURATE(1)) dut_sat (
    .CLK(clk), .RST(rst), .START(start), .N(n), .MODE(mode), .A(a),
    .A_VALID(a_valid), .Q(q_s), .CNT(cnt_s), .BUSY(busy_s), .DONE(done_s),
    .OVF(ovf_s)
  );

  // Clock runs only when enabled so reset can be shown acting with it idle.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then advance past the next rising edge.
  task automatic applyStimulus(input logic st, input logic [3:0] nn,
                               input logic md, input logic [7:0] aa,
                               input logic av);
    start   = st;
    n       = nn;
    mode    = md;
    a       = aa;
    a_valid = av;
    @(posedge clk);
    #1;
  endtask

  // Compare the full observable state of the wrapping instance.
  task automatic checkWrap(input string tag, input logic [7:0] eq,
                           input logic [3:0] ec, input logic eb,
                           input logic ed, input logic eo);
    checkOutput({tag, ".q"},    32'(q_w),    32'(eq));
    checkOutput({tag, ".cnt"},  32'(cnt_w),  32'(ec));
    checkOutput({tag, ".busy"}, 32'(busy_w), 32'(eb));
    checkOutput({tag, ".done"}, 32'(done_w), 32'(ed));
    checkOutput({tag, ".ovf"},  32'(ovf_w),  32'(eo));
  endtask

  logic [7:0] t2_a [5];
  logic [7:0] t2_q [5];

  // Test 4 vectors: {start, a_valid, a, expected q, expected cnt, expected done}
  logic       t4_st [5];
  logic       t4_av [5];
  logic [7:0] t4_a  [5];
  logic [7:0] t4_q  [5];
  logic [3:0] t4_c  [5];
  logic       t4_d  [5];

  initial begin
    t2_a = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd16};
    t2_q = '{8'd1, 8'd3, 8'd7, 8'd15, 8'd31};
    t4_st = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    t4_av = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    t4_a  = '{8'd3, 8'd99, 8'd4, 8'd99, 8'd5};
    t4_q  = '{8'd3, 8'd3, 8'd7, 8'd7, 8'd12};
    t4_c  = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3};
    t4_d  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    clk_en  = 1'b0;
    rst     = 1'b0;
    start   = 1'b0;
    n       = '0;
    mode    = 1'b0;
    a       = '0;
    a_valid = 1'b0;

    // Test 1: asynchronous reset with the clock stopped, then held with START.
    $display("[TB] test 1: asynchronous reset");
    #3 rst = 1'b1;
    #1;
    checkWrap("t1_async", 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_async.sat_q", 32'(q_s), 32'd0);
    clk_en = 1'b1;
    applyStimulus(1'b1, 4'd3, 1'b0, 8'd5, 1'b1);
    applyStimulus(1'b1, 4'd3, 1'b0, 8'd5, 1'b1);
    checkWrap("t1_held", 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
    checkWrap("t1_idle", 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Test 2: five-sample add run.
    $display("[TB] test 2: basic accumulation");
    applyStimulus(1'b1, 4'd5, 1'b0, 8'd0, 1'b0);
    checkWrap("t2_start", 8'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'd0, 1'b0, t2_a[i], 1'b1);
      checkWrap($sformatf("t2_s%0d", i), t2_q[i], 4'(i + 1),
                (i < 4) ? 1'b1 : 1'b0, (i == 4) ? 1'b1 : 1'b0, 1'b0);
      checkOutput($sformatf("t2_s%0d.sat_q", i), 32'(q_s), 32'(t2_q[i]));
    end
    applyStimulus(1'b0, 4'd0, 1'b0, 8'd50, 1'b1);
    checkWrap("t2_idle1", 8'd31, 4'd5, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'd50, 1'b1);
    checkWrap("t2_idle2", 8'd31, 4'd5, 1'b0, 1'b0, 1'b0);

    // Test 3: add overflow (wrap vs saturate) and subtract underflow.
    $display("[TB] test 3: overflow handling");
    applyStimulus(1'b1, 4'd2, 1'b0, 8'd0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'd200, 1'b1);
    checkWrap("t3_add1", 8'd200, 4'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'd100, 1'b1);
    checkWrap("t3_add2", 8'd44, 4'd2, 1'b0, 1'b1, 1'b1);
    checkOutput("t3_add2.sat_q",   32'(q_s),   32'd255);
    checkOutput("t3_add2.sat_ovf", 32'(ovf_s), 32'd1);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
    applyStimulus(1'b1, 4'd2, 1'b1, 8'd0, 1'b0);
    checkOutput("t3_sub_start.ovf", 32'(ovf_w), 32'd0);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'd3, 1'b1);
    checkOutput("t3_sub1.sat_q",   32'(q_s),   32'd0);
    checkOutput("t3_sub1.sat_ovf", 32'(ovf_s), 32'd1);
    checkOutput("t3_sub1.wrap_q",  32'(q_w),   32'd253);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'd5, 1'b1);
    checkOutput("t3_sub2.sat_q",   32'(q_s),    32'd0);
    checkOutput("t3_sub2.sat_ovf", 32'(ovf_s),  32'd1);
    checkOutput("t3_sub2.sat_done", 32'(done_s), 32'd1);
    checkWrap("t3_sub2", 8'd248, 4'd2, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'd0, 1'b0);

    // Test 4: gaps in A_VALID and START pulses during the run.
    $display("[TB] test 4: gaps and ignored START");
    applyStimulus(1'b1, 4'd3, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(t4_st[i], 4'd0, 1'b1, t4_a[i], t4_av[i]);
      checkWrap($sformatf("t4_v%0d", i), t4_q[i], t4_c[i],
                ~t4_d[i], t4_d[i], 1'b0);
    end
    applyStimulus(1'b1, 4'd0, 1'b1, 8'd99, 1'b1);
    checkWrap("t4_after", 8'd12, 4'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'd99, 1'b1);
    checkWrap("t4_idle", 8'd12, 4'd3, 1'b0, 1'b0, 1'b0);

    // Test 5: zero-length run, then a single-sample run.
    $display("[TB] test 5: zero-length run");
    applyStimulus(1'b1, 4'd0, 1'b0, 8'd0, 1'b0);
    checkWrap("t5_n0", 8'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
    checkWrap("t5_idle", 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd1, 1'b0, 8'd0, 1'b0);
    checkOutput("t5_n1.busy", 32'(busy_w), 32'd1);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'd7, 1'b1);
    checkWrap("t5_n1", 8'd7, 4'd1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'd0, 1'b0);

    // Test 6: reset aborts a run mid-way.
    $display("[TB] test 6: reset mid-run");
    applyStimulus(1'b1, 4'd4, 1'b0, 8'd0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'd2, 1'b1);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'd3, 1'b1);
    checkWrap("t6_mid", 8'd5, 4'd2, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkWrap("t6_rst", 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'd0, 1'b0, 8'd9, 1'b1);
      checkWrap($sformatf("t6_post%0d", i), 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 4'd1, 1'b0, 8'd0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'd9, 1'b1);
    checkWrap("t6_new", 8'd9, 4'd1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
    checkWrap("t6_end", 8'd9, 4'd1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
